round_scheduler: RTL and testbench

ROUND_SCHEDULER -- requirements
Module: round_scheduler

---
 rtl/round_scheduler_if.sv | 21 ++
 rtl/round_scheduler.sv | 158 +++++++++++++++
 tb/tb_round_scheduler.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/round_scheduler_if.sv
// Player-facing bundle of the memory-game round scheduler:
// start/keys in; note, state code, length and result flags out.
interface round_scheduler_if;
  logic       start;
  logic [3:0] keys;
  logic [3:0] note_out;
  logic [3:0] state;
  logic [4:0] round_len;
  logic       won;
  logic       lost;

  modport master (
    output start, keys,
    input  note_out, state, round_len, won, lost
  );

  modport slave (
    input  start, keys,
    output note_out, state, round_len, won, lost
  );
endinterface

// File: rtl/round_scheduler.sv
// Simon-style round scheduler: grows an LFSR note sequence, plays it back, checks replies.
// ROUND_SCHEDULER_TIMEOUT_EN adds a no-press timeout in WAIT_KEY.
module round_scheduler #(
  parameter int         MAX_LEN       = 16,
  parameter int         NOTE_TICKS    = 25000000,
  parameter int         GAP_TICKS     = 12500000,
  parameter int         TIMEOUT_TICKS = 250000000,
  parameter logic [7:0] SEED          = 8'hA5
) (
  input  logic clk,
  input  logic resetn,
  round_scheduler_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    APPEND   = 4'd1,
    PLAY_ON  = 4'd2,
    PLAY_GAP = 4'd3,
    WAIT_KEY = 4'd4,
    WAIT_REL = 4'd5,
    WON      = 4'd6,
    LOST     = 4'd7
  } state_t;

  state_t      st, st_n;
  logic [1:0]  mem [16];
  logic [4:0]  len;
  logic [3:0]  idx;
  logic [31:0] tick;
  logic [7:0]  lfsr;
  logic [3:0]  prev_keys;
  logic        won_q, lost_q;

  logic        len_clr, append;
  logic        idx_clr, idx_inc;
  logic        tick_clr, tick_inc;
  logic [3:0]  note;
  logic [3:0]  hit;
  logic        last, press;

  assign hit   = 4'b0001 << mem[idx];
  assign last  = ({1'b0, idx} == len - 5'd1);
  assign press = (bus.keys != 4'd0) && (prev_keys == 4'd0);

  always_comb begin
    st_n     = st;
    len_clr  = 1'b0;
    append   = 1'b0;
    idx_clr  = 1'b0;
    idx_inc  = 1'b0;
    tick_clr = 1'b0;
    tick_inc = 1'b0;
    note     = 4'd0;
    unique case (st)
      IDLE, WON, LOST: begin
        if (bus.start) begin
          len_clr = 1'b1;
          st_n    = APPEND;
        end
      end
      APPEND: begin
        append   = 1'b1;
        idx_clr  = 1'b1;
        tick_clr = 1'b1;
        st_n     = PLAY_ON;
      end
      PLAY_ON: begin
        note = hit;
        if (tick == 32'(NOTE_TICKS - 1)) begin
          tick_clr = 1'b1;
          st_n     = PLAY_GAP;
        end else begin
          tick_inc = 1'b1;
        end
      end
      PLAY_GAP: begin
        if (tick == 32'(GAP_TICKS - 1)) begin
          tick_clr = 1'b1;
          if (last) begin
            idx_clr = 1'b1;
            st_n    = WAIT_KEY;
          end else begin
            idx_inc = 1'b1;
            st_n    = PLAY_ON;
          end
        end else begin
          tick_inc = 1'b1;
        end
      end
      WAIT_KEY: begin
        note = bus.keys;
        if (press) begin
          st_n = (bus.keys == hit) ? WAIT_REL : LOST;
        end
`ifdef ROUND_SCHEDULER_TIMEOUT_EN
        else if (tick == 32'(TIMEOUT_TICKS - 1)) begin
          st_n = LOST;
        end else begin
          tick_inc = 1'b1;
        end
`endif
      end
      WAIT_REL: begin
        note = bus.keys;
        // tick restarts so every WAIT_KEY entry times out afresh
        tick_clr = 1'b1;
        if (bus.keys == 4'd0) begin
          if (last) begin
            st_n = (len == 5'(MAX_LEN)) ? WON : APPEND;
          end else begin
            idx_inc = 1'b1;
            st_n    = WAIT_KEY;
          end
        end else if (bus.keys != prev_keys) begin
          st_n = LOST;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st        <= IDLE;
      len       <= 5'd0;
      idx       <= 4'd0;
      tick      <= 32'd0;
      lfsr      <= SEED;
      prev_keys <= 4'd0;
      won_q     <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      st        <= st_n;
      prev_keys <= bus.keys;
      won_q     <= (st_n == WON);
      lost_q    <= (st_n == LOST);
      if (len_clr)     len <= 5'd0;
      else if (append) len <= len + 5'd1;
      if (idx_clr)      idx <= 4'd0;
      else if (idx_inc) idx <= idx + 4'd1;
      if (tick_clr)      tick <= 32'd0;
      else if (tick_inc) tick <= tick + 32'd1;
      if (append) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  always_ff @(posedge clk) begin
    if (append) mem[len[3:0]] <= lfsr[1:0];
  end

  assign bus.note_out  = note;
  assign bus.state     = st;
  assign bus.round_len = len;
  assign bus.won       = won_q;
  assign bus.lost      = lost_q;

endmodule

// File: tb/tb_round_scheduler.sv
// Randomised game-level bench for round_scheduler against a note-list model.
// Define ROUND_SCHEDULER_TIMEOUT_EN for both bench and RTL to exercise the timeout.
module tb_round_scheduler;
  localparam int         NT = 2;
  localparam int         GT = 1;
  localparam int         ML = 2;
  localparam int         TO = 5;
  localparam logic [7:0] SD = 8'hA5;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  round_scheduler_if bus();

  round_scheduler #(
    .MAX_LEN(ML), .NOTE_TICKS(NT), .GAP_TICKS(GT),
    .TIMEOUT_TICKS(TO), .SEED(SD)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus.slave)
  );

  int errs = 0;
  int checks = 0;
  logic [7:0] lfsr_m;
  int notes[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lfsr_next(logic [7:0] v);
    return {v[6:0], ^(v & 8'b1011_1000)};
  endfunction

  task automatic hard_reset();
    resetn = 1'b0;
    #1;
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_note", 32'(bus.note_out), 0);
    chk("rst_len", 32'(bus.round_len), 0);
    chk("rst_won", 32'(bus.won), 0);
    chk("rst_lost", 32'(bus.lost), 0);
    lfsr_m = SD;
    #2 resetn = 1'b1;
    step();
  endtask

  task automatic start_game();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("start_append", 32'(bus.state), 1);
    chk("start_len", 32'(bus.round_len), 0);
    notes.delete();
  endtask

  // entered with the DUT in APPEND; leaves it at the first WAIT_KEY cycle
  task automatic play_round();
    notes.push_back(int'(lfsr_m[1:0]));
    lfsr_m = lfsr_next(lfsr_m);
    step();
    foreach (notes[i]) begin
      repeat (NT) begin
        chk("play_state", 32'(bus.state), 2);
        chk("play_note", 32'(bus.note_out), 32'(1 << notes[i]));
        step();
      end
      repeat (GT) begin
        chk("gap_state", 32'(bus.state), 3);
        chk("gap_note", 32'(bus.note_out), 0);
        step();
      end
    end
    chk("wait_state", 32'(bus.state), 4);
    chk("round_len", 32'(bus.round_len), 32'(notes.size()));
  endtask

  // res: 0 lost, 1 won, 2 next round started
  task automatic respond(input int always_ok, output int res);
    int want, k, k2, roll;
    res = 0;
    foreach (notes[i]) begin
      repeat ($urandom_range(0, 3)) begin
        chk("idle_state", 32'(bus.state), 4);
        step();
      end
      want = 1 << notes[i];
      roll = always_ok ? 15 : int'($urandom_range(0, 15));
      k = want;
      if (roll == 0) begin
        do k = int'($urandom_range(1, 15)); while (k == want);
      end
      bus.keys = 4'(k);
      #1;
      chk("echo", 32'(bus.note_out), 32'(k));
      step();
      if (k != want) begin
        chk("bad_state", 32'(bus.state), 7);
        chk("bad_lost", 32'(bus.lost), 1);
        bus.keys = 4'd0;
        return;
      end
      chk("rel_state", 32'(bus.state), 5);
      repeat ($urandom_range(0, 2)) begin
        step();
        chk("hold_state", 32'(bus.state), 5);
      end
      if (roll == 1) begin
        do k2 = int'($urandom_range(1, 15)); while (k2 == k);
        bus.keys = 4'(k2);
        step();
        chk("chg_state", 32'(bus.state), 7);
        chk("chg_lost", 32'(bus.lost), 1);
        bus.keys = 4'd0;
        return;
      end
      bus.keys = 4'd0;
      step();
      if (i == notes.size() - 1) begin
        if (notes.size() == ML) begin
          chk("won_state", 32'(bus.state), 6);
          chk("won_flag", 32'(bus.won), 1);
          chk("won_lost", 32'(bus.lost), 0);
          res = 1;
        end else begin
          chk("next_append", 32'(bus.state), 1);
          res = 2;
        end
        return;
      end
      chk("next_key", 32'(bus.state), 4);
    end
  endtask

  initial begin
    int r;
    bus.start = 1'b0;
    bus.keys  = 4'd0;
    lfsr_m    = SD;
    #12;
    chk("por_state", 32'(bus.state), 0);
    chk("por_note", 32'(bus.note_out), 0);
    chk("por_len", 32'(bus.round_len), 0);
    resetn = 1'b1;
    step();

    // full winning game
    start_game();
    play_round();
    chk("first_note", 32'(notes[0]), 1);
    respond(1, r);
    chk("round1_res", 32'(r), 2);
    play_round();
    chk("second_note", 32'(notes[1]), 2);
    respond(1, r);
    chk("round2_res", 32'(r), 1);

    // reset during playback abandons the game
    start_game();
    step();
    chk("mid_on", 32'(bus.state), 2);
    hard_reset();
    start_game();
    play_round();
    chk("replay_note", 32'(notes[0]), 1);
    bus.keys = 4'b0011;
    #1;
    chk("multi_echo", 32'(bus.note_out), 3);
    step();
    chk("multi_state", 32'(bus.state), 7);
    chk("multi_lost", 32'(bus.lost), 1);
    bus.keys = 4'd0;

    // no press while waiting
    start_game();
    play_round();
`ifdef ROUND_SCHEDULER_TIMEOUT_EN
    repeat (TO - 1) begin
      step();
      chk("to_wait", 32'(bus.state), 4);
    end
    step();
    chk("to_lost", 32'(bus.state), 7);
    chk("to_flag", 32'(bus.lost), 1);
`else
    repeat (100) step();
    chk("no_to", 32'(bus.state), 4);
`endif
    hard_reset();

    for (int g = 0; g < 40; g++) begin
      start_game();
      do begin
        play_round();
        respond(0, r);
      end while (r == 2);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
